// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage RISC-V pipeline.
// Tracks E/M/W destination-register state and produces the operand forward
// selects plus stall/flush controls for load-use, taken branches and
// multi-cycle mul/div occupancy of EX.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4  // total EX cycles of a mul/div, 2..16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       RegWriteD,
  input  logic       LoadD,
  input  logic       PCSrcE,
  input  logic       MulDivE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  // The counter starts two below the latency: the IDLE cycle and the final
  // release cycle are not counted.
  localparam logic [3:0] CNT_INIT = 4'(MULDIV_LAT - 2);

  // Tracked pipeline state
  logic [4:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;
  logic       reg_write_e_q, reg_write_e_d, load_e_q, load_e_d;
  logic [4:0] rd_m_q, rd_m_d, rd_w_q, rd_w_d;
  logic       reg_write_m_q, reg_write_m_d, reg_write_w_q, reg_write_w_d;

  // Mul/div occupancy FSM
  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic lu, md_stall;

  // Select the youngest in-flight producer of rs; MEM beats WB, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       we_m, input logic [4:0] rd_m,
                                         input logic       we_w, input logic [4:0] rd_w);
    if (we_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  // Hazard detection and all combinational control outputs
  always_comb begin
    // Conservative load-use: an unused source field still triggers a stall.
    lu       = load_e_q && (rd_e_q != 5'd0) && (rd_e_q == Rs1D || rd_e_q == Rs2D);
    md_stall = MulDivE && !(state_q == BUSY && cnt_q == 4'd0);

    ForwardAE = fwd_sel(rs1_e_q, reg_write_m_q, rd_m_q, reg_write_w_q, rd_w_q);
    ForwardBE = fwd_sel(rs2_e_q, reg_write_m_q, rd_m_q, reg_write_w_q, rd_w_q);

    StallE = md_stall;
    StallF = md_stall || lu;
    StallD = md_stall || lu;
    // A stalled mul/div must never be killed; flushes wait until EX advances.
    FlushE = (lu || PCSrcE) && !md_stall;
    FlushD = PCSrcE && !md_stall;
  end

  // Mul/div FSM next state: count down the remaining EX occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (MulDivE) begin
        state_d = BUSY;
        cnt_d   = CNT_INIT;
      end
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      state_d = IDLE;
    end
  end

  // Pipeline tracking next state: hold/flush/capture E, bubble M while EX stalls.
  always_comb begin
    rs1_e_d       = Rs1D;
    rs2_e_d       = Rs2D;
    rd_e_d        = RdD;
    reg_write_e_d = RegWriteD;
    load_e_d      = LoadD;
    if (StallE) begin
      rs1_e_d       = rs1_e_q;
      rs2_e_d       = rs2_e_q;
      rd_e_d        = rd_e_q;
      reg_write_e_d = reg_write_e_q;
      load_e_d      = load_e_q;
    end else if (FlushE) begin
      rs1_e_d       = 5'd0;
      rs2_e_d       = 5'd0;
      rd_e_d        = 5'd0;
      reg_write_e_d = 1'b0;
      load_e_d      = 1'b0;
    end

    rd_m_d        = StallE ? 5'd0 : rd_e_q;
    reg_write_m_d = StallE ? 1'b0 : reg_write_e_q;

    rd_w_d        = rd_m_q;
    reg_write_w_d = reg_write_m_q;
  end

  // State registers; reset discards any in-flight mul/div.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      rs1_e_q       <= 5'd0;
      rs2_e_q       <= 5'd0;
      rd_e_q        <= 5'd0;
      reg_write_e_q <= 1'b0;
      load_e_q      <= 1'b0;
      rd_m_q        <= 5'd0;
      reg_write_m_q <= 1'b0;
      rd_w_q        <= 5'd0;
      reg_write_w_q <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
    end else begin
      rs1_e_q       <= rs1_e_d;
      rs2_e_q       <= rs2_e_d;
      rd_e_q        <= rd_e_d;
      reg_write_e_q <= reg_write_e_d;
      load_e_q      <= load_e_d;
      rd_m_q        <= rd_m_d;
      reg_write_m_q <= reg_write_m_d;
      rd_w_q        <= rd_w_d;
      reg_write_w_q <= reg_write_w_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: hand-derived directed vectors,
// a mid-BUSY reset sequence, and randomized traffic against a pipeline model.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD, LoadD, PCSrcE, MulDivE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE;

  hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .LoadD(LoadD), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE)
  );

  always #5 clk = ~clk;

  // Output bundle: {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE}
  logic [8:0] dut_out;
  assign dut_out = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (fa fb sf sd se fd fe)", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       we, ld, pc, md;
    logic [8:0] exp;
  } vec_t;

  function automatic vec_t mkv(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we, input logic ld,
                               input logic pc, input logic md, input logic [8:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.ld = ld;
    v.pc = pc; v.md = md; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd; RegWriteD = v.we;
    LoadD = v.ld; PCSrcE = v.pc; MulDivE = v.md;
  endtask

  // Apply one cycle of inputs, check mid-cycle, advance past the next edge.
  task automatic step(input vec_t v, input string name);
    drive(v);
    #2;
    check(name, dut_out, v.exp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       we, ld;
  } slot_t;

  localparam slot_t EMPTY = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, we: 1'b0, ld: 1'b0};

  slot_t m_e, m_m, m_w;
  int    md_age;  // cycles the current mul/div has already spent in EX

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (m_m.we && m_m.rd != 0 && m_m.rd == rs) return 2'b10;
    if (m_w.we && m_w.rd != 0 && m_w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic ref_reset();
    m_e = EMPTY; m_m = EMPTY; m_w = EMPTY; md_age = 0;
  endtask

  // Expected outputs for the current model state and inputs; also advances the
  // model as the clock edge would.
  task automatic ref_cycle(input vec_t v, output logic [8:0] exp);
    logic  hold, lu, fe, fd;
    slot_t d;
    hold = v.md && (md_age < LAT - 1);
    lu   = m_e.ld && m_e.rd != 0 && (m_e.rd == v.rs1 || m_e.rd == v.rs2);
    fe   = (lu || v.pc) && !hold;
    fd   = v.pc && !hold;
    exp  = {ref_fwd(m_e.rs1), ref_fwd(m_e.rs2), hold || lu, hold || lu, hold, fd, fe};
    d = '{rs1: v.rs1, rs2: v.rs2, rd: v.rd, we: v.we, ld: v.ld};
    m_w = m_m;
    m_m = hold ? EMPTY : m_e;
    if (!hold) m_e = fe ? EMPTY : d;
    md_age = hold ? md_age + 1 : 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vq[$];
    vec_t v;
    logic [8:0] exp;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive(mkv(0, 0, 0, 0, 0, 0, 0, 9'b0));
    #2;
    check("reset_outputs", dut_out, 9'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---------------- directed vector table ----------------
    //                rs1 rs2 rd we ld pc md  fa_fb_sf sd se fd fe
    vq.push_back(mkv( 0,  0,  0, 0, 0, 0, 0, 9'b00_00_00000)); // idle
    vq.push_back(mkv( 1,  2,  5, 1, 0, 0, 0, 9'b00_00_00000)); // add x5
    vq.push_back(mkv( 5,  3, 10, 1, 0, 0, 0, 9'b00_00_00000)); // reader A of x5
    vq.push_back(mkv( 5,  6,  0, 0, 0, 0, 0, 9'b10_00_00000)); // A in EX: MEM fwd
    vq.push_back(mkv( 0,  0,  0, 1, 0, 0, 0, 9'b01_00_00000)); // B in EX: WB fwd
    vq.push_back(mkv( 0,  0,  0, 0, 0, 0, 0, 9'b00_00_00000)); // reader of x0
    vq.push_back(mkv( 0,  0,  7, 1, 0, 0, 0, 9'b00_00_00000)); // writer x7 #1
    vq.push_back(mkv( 0,  0,  7, 1, 0, 0, 0, 9'b00_00_00000)); // writer x7 #2
    vq.push_back(mkv( 0,  7,  0, 0, 0, 0, 0, 9'b00_00_00000)); // reader rs2=7
    vq.push_back(mkv( 0,  0,  0, 0, 0, 0, 0, 9'b00_10_00000)); // MEM writer wins
    vq.push_back(mkv( 1,  0,  6, 1, 1, 0, 0, 9'b00_00_00000)); // load x6
    vq.push_back(mkv( 6,  2,  8, 1, 0, 0, 0, 9'b00_00_11001)); // load-use stall
    vq.push_back(mkv( 6,  2,  8, 1, 0, 0, 0, 9'b00_00_00000)); // bubble in EX
    vq.push_back(mkv( 0,  0,  0, 0, 0, 0, 0, 9'b01_00_00000)); // consumer sees WB
    vq.push_back(mkv( 0,  0,  3, 1, 0, 1, 0, 9'b00_00_00011)); // taken branch
    vq.push_back(mkv( 3,  3,  0, 0, 0, 0, 0, 9'b00_00_00000)); // flushes gone
    vq.push_back(mkv( 0,  0,  0, 0, 0, 0, 0, 9'b00_00_00000)); // no fwd from flushed x3
    vq.push_back(mkv( 0,  0,  9, 1, 0, 0, 0, 9'b00_00_00000)); // writer x9
    vq.push_back(mkv( 1,  2,  4, 1, 0, 0, 0, 9'b00_00_00000)); // mul/div enters ID
    vq.push_back(mkv( 9,  0,  6, 1, 1, 0, 1, 9'b00_00_11100)); // md cycle 1
    vq.push_back(mkv( 9,  0,  6, 1, 1, 0, 1, 9'b00_00_11100)); // md cycle 2
    vq.push_back(mkv( 9,  0,  6, 1, 1, 0, 1, 9'b00_00_11100)); // md cycle 3
    vq.push_back(mkv( 9,  0,  6, 1, 1, 0, 1, 9'b00_00_00000)); // md cycle 4: release
    vq.push_back(mkv( 6,  0,  0, 0, 0, 0, 0, 9'b00_00_11001)); // load-use honoured
    vq.push_back(mkv( 6,  0,  0, 0, 0, 0, 0, 9'b00_00_00000)); // bubble
    vq.push_back(mkv( 0,  0,  0, 0, 0, 0, 0, 9'b01_00_00000)); // consumer sees WB
    foreach (vq[i]) step(vq[i], $sformatf("vec%0d", i));

    // ---------------- reset in the 2nd BUSY cycle ----------------
    step(mkv( 0,  0, 20, 1, 0, 0, 0, 9'b00_00_00000), "rst_seq_w20");
    step(mkv(20, 20, 21, 1, 0, 0, 0, 9'b00_00_00000), "rst_seq_md_id");
    step(mkv( 0,  0,  0, 0, 0, 0, 1, 9'b10_10_11100), "rst_seq_idle");
    step(mkv( 0,  0,  0, 0, 0, 0, 1, 9'b01_01_11100), "rst_seq_busy1");
    drive(mkv(0, 0, 0, 0, 0, 0, 1, 9'b0));
    #2;
    check("rst_seq_busy2", dut_out, 9'b00_00_11100);
    drive(mkv(0, 0, 0, 0, 0, 0, 0, 9'b0));
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", dut_out, 9'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(mkv(0, 0, 0, 0, 0, 0, 1, 9'b00_00_11100), "rst_restart_1");
    step(mkv(0, 0, 0, 0, 0, 0, 1, 9'b00_00_11100), "rst_restart_2");
    step(mkv(0, 0, 0, 0, 0, 0, 1, 9'b00_00_11100), "rst_restart_3");
    step(mkv(0, 0, 0, 0, 0, 0, 1, 9'b00_00_00000), "rst_restart_4");
    // Back-to-back: a second mul/div starts from IDLE right after release.
    step(mkv(0, 0, 0, 0, 0, 0, 1, 9'b00_00_11100), "b2b_1");
    step(mkv(0, 0, 0, 0, 0, 0, 1, 9'b00_00_11100), "b2b_2");
    step(mkv(0, 0, 0, 0, 0, 0, 1, 9'b00_00_11100), "b2b_3");
    step(mkv(0, 0, 0, 0, 0, 0, 1, 9'b00_00_00000), "b2b_4");

    // ---------------- randomized traffic vs model ----------------
    rst_n = 1'b0;
    drive(mkv(0, 0, 0, 0, 0, 0, 0, 9'b0));
    ref_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));
      v.rd  = 5'($urandom_range(0, 7));
      v.ld  = ($urandom_range(0, 3) == 0);
      v.we  = v.ld || ($urandom_range(0, 1) == 1);
      // A mul/div stays in EX until released and never shares EX with a load.
      if (md_age > 0)   v.md = 1'b1;
      else if (m_e.ld)  v.md = 1'b0;
      else              v.md = ($urandom_range(0, 5) == 0);
      v.pc  = v.md ? 1'b0 : ($urandom_range(0, 7) == 0);
      ref_cycle(v, exp);
      v.exp = exp;
      step(v, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the 5-stage RISC-V pipeline. It tracks destination-register state for the EX, MEM and WB stages internally, and drives the 2-bit select inputs of the two EX-stage operand forwarding muxes. It also generates the fetch, decode and execute stall/flush controls for three hazard types: load-use, taken branch/jump, and multi-cycle mul/div occupancy of EX.

## Interface
Parameters:
- MULDIV_LAT, 4, total cycles a mul/div instruction occupies EX; legal range 2..16.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Rs1D  in  5  source register 1 of the instruction in ID.
- Rs2D  in  5  source register 2 of the instruction in ID.
- RdD  in  5  destination register of the instruction in ID.
- RegWriteD  in  1  the ID instruction writes the register file.
- LoadD  in  1  the ID instruction is a load (result taken from memory).
- PCSrcE  in  1  a branch/jump in EX is taken.
- MulDivE  in  1  the instruction in EX is a multi-cycle mul/div.
- ForwardAE  out  2  select for the rs1 operand mux: 00 register file, 01 WB result, 10 MEM ALU result; 11 never driven.
- ForwardBE  out  2  select for the rs2 operand mux, same encoding as ForwardAE.
- StallF  out  1  hold the PC.
- StallD  out  1  hold the IF/ID register.
- StallE  out  1  hold the ID/EX register; EX busy.
- FlushD  out  1  clear the IF/ID register.
- FlushE  out  1  clear the ID/EX register (insert a bubble).

## Operation
Internal tracking registers; all are reset to 0:
- E stage: Rs1E, Rs2E, RdE, RegWriteE, LoadE.
- M stage: RdM, RegWriteM.
- W stage: RdW, RegWriteW.

Forwarding (combinational from tracked state), shown for ForwardAE; ForwardBE is identical using Rs2E:
- 10 if RegWriteM and RdM≠0 and RdM==Rs1E.
- Otherwise 01 if RegWriteW and RdW≠0 and RdW==Rs1E.
- Otherwise 00.
- When both M and W match, M wins.

Load-use hazard:
- lu = LoadE and RdE≠0 and (RdE==Rs1D or RdE==Rs2D).
- This check is conservative: unused source fields still stall.

Mul/div FSM:
- States are IDLE and BUSY, with a counter cnt of 4 bits.
- IDLE with MulDivE=1: go to BUSY, cnt ← MULDIV_LAT−2.
- BUSY with cnt≠0: cnt ← cnt−1.
- BUSY with cnt==0: go to IDLE.
- md_stall = MulDivE and not (BUSY and cnt==0).

Outputs:
- StallE = md_stall.
- StallF = StallD = md_stall or lu.
- FlushE = (lu or PCSrcE) and not md_stall.
- FlushD = PCSrcE and not md_stall.

Register update on each edge:
- E stage:
  - If StallE: hold.
  - Else if FlushE: clear all E fields to 0.
  - Else: capture Rs1D, Rs2D, RdD, RegWriteD, LoadD.
- M stage:
  - If StallE: bubble (RegWriteM←0, RdM←0).
  - Else: capture RdE and RegWriteE.
- W stage: always capture RdM and RegWriteM.

Preconditions (the datapath guarantees these):
- PCSrcE and MulDivE are never both 1.
- MulDivE does not coincide with LoadE.

## Timing
- Forward, stall and flush outputs are combinational from tracked state and current inputs, settling in the same cycle.
- Tracked state changes only at the clock edge.
- Reset values:
  - All tracked registers are 0, the FSM is IDLE and cnt is 0.
  - ForwardAE/ForwardBE are 00.
  - With all inputs 0, every stall and flush output is 0.
- rst_n low asynchronously clears all state, including mid-BUSY; the aborted mul/div is discarded.
- Load-use stalls for exactly 1 cycle. The consumer then reaches EX with the load in WB and sees Forward=01.
- Taken branch: FlushD and FlushE are high for exactly the cycle PCSrcE is high.
- Mul/div holds EX for exactly MULDIV_LAT cycles. StallE is high for MULDIV_LAT−1 cycles, and MULDIV_LAT−1 bubbles enter MEM.
- Back-to-back mul/div: the second one starts from IDLE in the cycle after the first leaves EX.
- A load-use or branch coinciding with md_stall is deferred. FlushE is masked so the mul/div is never killed, and lu is re-evaluated once EX advances.

## Test plan
- Dependent ALU ops:
  - Stimulus: add x5 (RegWriteD=1, RdD=5), then an instruction with Rs1D=5 on the next cycle.
  - Required: in the consumer's EX cycle ForwardAE=10, ForwardBE=00. With one independent instruction between them, ForwardAE=01.
- x0 and priority:
  - Stimulus 1: a write to RdD=0 followed by a reader of x0. Required: Forward stays 00.
  - Stimulus 2: two consecutive writers of x7, then a reader with Rs2D=7. Required: ForwardBE=10 (the MEM-stage writer wins).
- Load-use:
  - Stimulus: LoadD=1 with RdD=6, next instruction Rs1D=6.
  - Required: StallF=StallD=FlushE=1 for 1 cycle, then the consumer is in EX with ForwardAE=01; no further stalls.
- Taken branch:
  - Stimulus: PCSrcE=1 for one cycle.
  - Required: FlushD=FlushE=1 in that cycle only. The following cycle has E-stage RegWriteE=0, so no forwarding from the flushed slot.
- Mul/div with MULDIV_LAT=4:
  - Stimulus: hold MulDivE=1 while StallE is high; the MEM-stage instruction writes x9 and a D-stage load-use is pending.
  - Required: StallE=StallF=StallD=1 for 3 cycles, StallE=0 on the 4th cycle, FlushE=0 throughout, and 3 bubbles in MEM. Load-use is honoured afterwards.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 in the 2nd BUSY cycle.
  - Required: immediately all outputs are 0 and Forward=00. After release with MulDivE=1, the full 4-cycle sequence restarts.
